serial_tx_ctrl: RTL and testbench



---
 rtl/serial_tx_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_tx_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_ctrl.sv
// Word serializer: frames 8-bit words LSB-first using an external 3-bit counter's
// carry as the end-of-word marker, with a one-entry holding buffer for gap-free output.
module serial_tx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cnt_en,
    input  logic       cnt_co,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic [7:0] words_sent,
    output logic       sync_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hold_data;
    logic       r_hold_full;
    logic [7:0] r_sr;
    logic [2:0] r_idx;
    logic [7:0] r_words_sent;
    logic       r_sync_err;
    logic       w_load;
    logic       w_accept;
    logic       w_word_end;
    logic       w_desync;

    assign in_ready   = ~r_hold_full;
    assign words_sent = r_words_sent;
    assign sync_err   = r_sync_err;

    // Hold can only accept while empty, so an accept and a drain never share an edge.
    assign w_accept   = in_valid & ~r_hold_full;
    assign w_word_end = (r_state == ST_SHIFT) & cnt_co;
    assign w_desync   = (r_state == ST_SHIFT) & (cnt_co != (r_idx == 3'd7));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and serial-side outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        cnt_en      = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = 1'b0;
        ser_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                cnt_en    = 1'b1;
                ser_valid = 1'b1;
                ser_out   = r_sr[0];
                ser_last  = cnt_co;
                // Word termination trusts the counter carry, not the shadow index.
                if (cnt_co) begin
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_data <= in_data;
            r_hold_full <= 1'b1;
        end
    end

    // Shift register and shadow bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= 8'h00;
            r_idx <= 3'd0;
        end else if (w_load) begin
            r_sr  <= r_hold_data;
            r_idx <= 3'd0;
        end else if (r_state == ST_SHIFT) begin
            r_sr  <= {1'b0, r_sr[7:1]};
            r_idx <= r_idx + 3'd1;
        end
    end

    // Completed-word counter and sticky counter/index disagreement flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_sent <= 8'h00;
            r_sync_err   <= 1'b0;
        end else begin
            if (w_word_end) begin
                r_words_sent <= r_words_sent + 8'd1;
            end
            if (w_desync) begin
                r_sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl with a behavioural 3-bit counter closing the
// cnt_en / cnt_co loop; a monitor records every valid serial bit.
module tb_serial_tx_ctrl;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       cnt_en;
    logic       cnt_co;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic [7:0] words_sent;
    logic       sync_err;

    logic [2:0] cnt;
    logic       force_co = 1'b0;
    int         cyc      = 0;
    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         last_acc = 0;

    bit cap_bits[$];
    bit cap_last[$];
    int cap_cyc[$];

    serial_tx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cnt_en     (cnt_en),
        .cnt_co     (cnt_co),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .words_sent (words_sent),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Shared 3-bit counter model; force_co injects a spurious carry.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 3'd0;
        else if (cnt_en) cnt <= cnt + 3'd1;
    end
    assign cnt_co = force_co | ((cnt == 3'd7) & cnt_en);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ser_valid === 1'b1) begin
            cap_bits.push_back(ser_out);
            cap_last.push_back(ser_last);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1; in_valid = 1'b0; force_co = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        cap_bits.delete(); cap_last.delete(); cap_cyc.delete();
    endtask

    task automatic send_word(input logic [7:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
        end
        #1 in_valid = 1'b1; in_data = d;
        @(negedge clk);
        last_acc = cyc;
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(in_ready === 1'b1 && ser_valid === 1'b0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_idle_timeout: ser_valid=%b in_ready=%b", ser_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if ({in_ready, ser_valid, cnt_en, ser_out, ser_last, sync_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 100000",
                     {in_ready, ser_valid, cnt_en, ser_out, ser_last, sync_err});
        end
        n_cmp++;
        if (words_sent !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_words: got %0d required 0", words_sent);
        end
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] bits, lasts;
        bit contig;
        do_reset();
        send_word(8'hA5);
        wait_idle();
        bits = 8'h00; lasts = 8'h00; contig = 1'b1;
        for (int i = 0; i < cap_bits.size() && i < 8; i++) begin
            bits[i]  = cap_bits[i];
            lasts[i] = cap_last[i];
            if (cap_cyc[i] != cap_cyc[0] + i) contig = 1'b0;
        end
        n_cmp++;
        if (cap_bits.size() != 8) begin
            n_fail++; $display("FAIL single_count: got %0d bits required 8", cap_bits.size());
        end
        n_cmp++;
        if (bits !== 8'hA5) begin
            n_fail++; $display("FAIL single_bits: got %h required a5", bits);
        end
        n_cmp++;
        if (lasts !== 8'h80) begin
            n_fail++; $display("FAIL single_last: got %h required 80", lasts);
        end
        n_cmp++;
        if (cap_cyc.size() == 0 || cap_cyc[0] != last_acc + 1 || !contig) begin
            n_fail++; $display("FAIL single_latency: first bit cycle %0d required %0d contig=%0d",
                               (cap_cyc.size() == 0) ? -1 : cap_cyc[0], last_acc + 1, contig);
        end
        n_cmp++;
        if (words_sent !== 8'd1 || cnt_en !== 1'b0 || sync_err !== 1'b0) begin
            n_fail++; $display("FAIL single_end: words=%0d cnt_en=%b sync_err=%b required 1,0,0",
                               words_sent, cnt_en, sync_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits, lasts;
        do_reset();
        send_word(8'h0F);
        send_word(8'hF0);
        wait_idle();
        bits = 16'h0000; lasts = 16'h0000;
        for (int i = 0; i < cap_bits.size() && i < 16; i++) begin
            bits[i]  = cap_bits[i];
            lasts[i] = cap_last[i];
        end
        n_cmp++;
        if (cap_bits.size() != 16 || cap_cyc[cap_cyc.size()-1] - cap_cyc[0] != 15) begin
            n_fail++; $display("FAIL b2b_contig: got %0d bits required 16 contiguous", cap_bits.size());
        end
        n_cmp++;
        if (bits !== 16'hF00F) begin
            n_fail++; $display("FAIL b2b_bits: got %h required f00f", bits);
        end
        n_cmp++;
        if (lasts !== 16'h8080) begin
            n_fail++; $display("FAIL b2b_last: got %h required 8080", lasts);
        end
        n_cmp++;
        if (words_sent !== 8'd2) begin
            n_fail++; $display("FAIL b2b_words: got %0d required 2", words_sent);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  w [3];
        logic [23:0] bits, lasts;
        bit prev;
        int k, t;
        w[0] = 8'h3C; w[1] = 8'hC3; w[2] = 8'h81;
        do_reset();
        k = 0; t = 0;
        @(negedge clk);
        prev = in_ready;
        #1 in_valid = 1'b1; in_data = w[0];
        while (k < 3 && t < 300) begin
            @(negedge clk);
            t++;
            if (prev) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_ready_drop: word %0d in_ready=%b required 0", k, in_ready);
                end
                k++;
                #1;
                if (k < 3) in_data = w[k];
                else in_valid = 1'b0;
            end
            prev = in_ready;
        end
        in_valid = 1'b0;
        if (k < 3) begin
            n_cmp++; n_fail++;
            $display("FAIL bp_timeout: accepted %0d required 3", k);
        end
        wait_idle();
        bits = 24'h0; lasts = 24'h0;
        for (int i = 0; i < cap_bits.size() && i < 24; i++) begin
            bits[i]  = cap_bits[i];
            lasts[i] = cap_last[i];
        end
        n_cmp++;
        if (cap_bits.size() != 24 || bits !== 24'h81C33C) begin
            n_fail++; $display("FAIL bp_bits: got %0d bits %h required 24 bits 81c33c", cap_bits.size(), bits);
        end
        n_cmp++;
        if (lasts !== 24'h808080 || words_sent !== 8'd3) begin
            n_fail++; $display("FAIL bp_last_words: last %h words %0d required 808080, 3", lasts, words_sent);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) send_word(8'h00);
        wait_idle();
        n_cmp++;
        if (words_sent !== 8'd255) begin
            n_fail++; $display("FAIL wrap_255: got %0d required 255", words_sent);
        end
        send_word(8'h00);
        wait_idle();
        n_cmp++;
        if (words_sent !== 8'd0 || sync_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_0: words %0d sync_err %b required 0, 0", words_sent, sync_err);
        end
        cap_bits.delete(); cap_last.delete(); cap_cyc.delete();
    endtask

    task automatic test_desync();
        logic [3:0] bits;
        int t;
        do_reset();
        send_word(8'hA5);
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            #1;
            if (cap_bits.size() >= 3) break;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_fail++; $display("FAIL desync_timeout: bits %0d required 3", cap_bits.size());
        end
        @(posedge clk);
        #1 force_co = 1'b1;
        @(posedge clk);
        #1 force_co = 1'b0;
        bits = 4'h0;
        for (int i = 0; i < cap_bits.size() && i < 4; i++) bits[i] = cap_bits[i];
        n_cmp++;
        if (cap_bits.size() != 4 || bits !== 4'h5 || cap_last[3] !== 1'b1) begin
            n_fail++; $display("FAIL desync_short: got %0d bits %h required 4 bits 5 with last", cap_bits.size(), bits);
        end
        n_cmp++;
        if (ser_valid !== 1'b0 || sync_err !== 1'b1 || words_sent !== 8'd1) begin
            n_fail++; $display("FAIL desync_end: valid %b sync_err %b words %0d required 0,1,1",
                               ser_valid, sync_err, words_sent);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sync_err !== 1'b1) begin
            n_fail++; $display("FAIL desync_sticky: got %b required 1", sync_err);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        bit seen;
        cap_bits.delete(); cap_last.delete(); cap_cyc.delete();
        send_word(8'h3C);
        t = 0;
        while (ser_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        send_word(8'h81);
        @(negedge clk);
        n_cmp++;
        if (ser_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre: valid %b in_ready %b required 1, 0", ser_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_valid, cnt_en, in_ready, ser_out, ser_last, sync_err} !== 6'b001000 || words_sent !== 8'd0) begin
            n_fail++; $display("FAIL mid_async: flags %b words %0d required 001000, 0",
                               {ser_valid, cnt_en, in_ready, ser_out, ser_last, sync_err}, words_sent);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ser_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen || words_sent !== 8'd0) begin
            n_fail++; $display("FAIL mid_discard: output seen %0d words %0d required none, 0", seen, words_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_desync();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
